// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry and FSM states.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a show-ahead head word and an occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset since the pointers are cleared.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | driving the start bit (low)
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (high); chains into the next frame if a byte is waiting
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ser_tx
);

  tx_state_e          state;
  logic [DIV_W-1:0]   baud_cnt;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         bit_idx;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               baud_done;

  assign tx_ready  = !wb_rst_i && !fifo_full;
  assign push      = tx_valid && tx_ready;
  assign baud_done = (baud_cnt == '0);
  assign pop       = !wb_rst_i && !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && baud_done));
  assign tx_busy   = (state != IDLE) || (fifo_level != '0);

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (push),
    .pop     (pop),
    .wr_data (tx_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Frame sequencer: bit timing by down-counter, divisor frozen at the start of each frame.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      ser_tx   <= 1'b1;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            ser_tx   <= 1'b0;
            shreg    <= fifo_head;
            div_q    <= clk_div;
            baud_cnt <= clk_div;
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            ser_tx   <= shreg[0];
            shreg    <= {1'b0, shreg[DATA_W-1:1]};
            bit_idx  <= '0;
            baud_cnt <= div_q;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= div_q;
            if (bit_idx == 3'd7) begin
              state  <= STOP;
              ser_tx <= 1'b1;
            end else begin
              ser_tx  <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              state    <= START;
              ser_tx   <= 1'b0;
              shreg    <= fifo_head;
              div_q    <= clk_div;
              baud_cnt <= clk_div;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          ser_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_uart_tx_engine;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic [DIV_W-1:0] clk_div  = '0;
  logic [7:0]       tx_data  = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic             tx_busy;
  logic             ser_tx;
  logic [LW-1:0]    fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  uart_tx_engine #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .clk_div    (clk_div),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .ser_tx     (ser_tx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: byte queue + current frame position ----------------
  int         mq[$];
  bit         m_active = 1'b0;
  logic [9:0] m_frame  = 10'h3ff;
  int         m_pos    = 0;
  int         m_div    = 0;
  logic       s_rst, s_val, s_pop, s_acc, exp_ser;
  logic [7:0] s_dat;
  int         s_div;

  always @(posedge wb_clk_i) begin
    s_rst = wb_rst_i;
    s_val = tx_valid;
    s_dat = tx_data;
    s_div = int'(clk_div);
    if (s_rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      s_pop = (mq.size() > 0) && (!m_active || (m_pos == 10 * (m_div + 1) - 1));
      s_acc = s_val && (mq.size() < DEPTH);
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * (m_div + 1)) m_active = 1'b0;
      end
      if (s_pop) begin
        m_frame  = {1'b1, 8'(mq.pop_front()), 1'b0};
        m_div    = s_div;
        m_pos    = 0;
        m_active = 1'b1;
      end
      if (s_acc) mq.push_back(int'(s_dat));
    end
    #1;
    exp_ser = m_active ? m_frame[m_pos / (m_div + 1)] : 1'b1;
    chk("model_line",  ser_tx,     exp_ser);
    chk("model_level", fifo_level, mq.size());
    chk("model_busy",  tx_busy,    (m_active || (mq.size() > 0)));
    chk("model_ready", tx_ready,   (!wb_rst_i && (mq.size() < DEPTH)));
  end

  // ---------------- output history sampled mid-cycle ----------------
  logic ser_h[$];
  logic busy_h[$];
  int   lvl_h[$];

  always @(negedge wb_clk_i) begin
    ser_h.push_back(ser_tx);
    busy_h.push_back(tx_busy);
    lvl_h.push_back(int'(fifo_level));
  end

  function automatic int find_low(input int from);
    for (int i = from; i < ser_h.size(); i++)
      if (ser_h[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int low_run(input int s);
    int n = 0;
    for (int i = s; i < ser_h.size(); i++) begin
      if (ser_h[i] !== 1'b0) break;
      n++;
    end
    return n;
  endfunction

  logic [7:0] rx_q[$];

  // Line decoder: finds each start edge and samples mid-bit for a known divisor.
  task automatic decode(input int from, input int div, input int n);
    int p;
    int s;
    logic [7:0] b;
    p = from;
    rx_q.delete();
    for (int k = 0; k < n; k++) begin
      s = find_low(p);
      if (s < 0 || (s + 9 * (div + 1) + div / 2) >= ser_h.size()) break;
      for (int j = 0; j < 8; j++) b[j] = ser_h[s + (j + 1) * (div + 1) + div / 2];
      chk("rx_stop_bit", ser_h[s + 9 * (div + 1) + div / 2], 1);
      rx_q.push_back(b);
      p = s + 9 * (div + 1) + div / 2 + 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
  endtask

  // ---------------- directed scenarios and random soak ----------------
  int         seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [7:0] bb[6];
  logic [7:0] b3[3];
  logic [9:0] fr;
  int mark, s, errs, peak, n, guard, g, zeros;
  logic rdy;

  initial begin
    // reset
    repeat (3) @(negedge wb_clk_i);
    chk("rst_ser",   ser_tx,     1);
    chk("rst_busy",  tx_busy,    0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready,   0);
    wb_rst_i = 1'b0;
    #1 chk("ready_after_release", tx_ready, 1);
    @(negedge wb_clk_i);

    // single byte 0xA5 at 5 cycles per bit
    clk_div = 16'd4;
    mark = ser_h.size();
    push_byte(8'hA5);
    run(70);
    s = find_low(mark);
    chk("a5_start_found", (s >= 0), 1);
    if (s >= 0) begin
      errs = 0;
      for (int i = 0; i < 50; i++) if (ser_h[s + i] !== 1'(seq_a5[i / 5])) errs++;
      chk("a5_wave_errs",  errs,           0);
      chk("a5_idle_after", ser_h[s + 50],  1);
      chk("a5_busy_last",  busy_h[s + 49], 1);
      chk("a5_busy_drop",  busy_h[s + 50], 0);
    end

    // back-to-back frames at 2 cycles per bit
    clk_div = 16'd1;
    b3[0] = 8'h41; b3[1] = 8'h42; b3[2] = 8'h43;
    mark = ser_h.size();
    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data = b3[k];
      @(negedge wb_clk_i);
    end
    tx_valid = 1'b0;
    run(70);
    peak = 0;
    for (int i = mark; i < lvl_h.size(); i++) if (lvl_h[i] > peak) peak = lvl_h[i];
    chk("b2b_level_peak", peak, 2);
    s = find_low(mark);
    chk("b2b_start_found", (s >= 0), 1);
    if (s >= 0) begin
      errs = 0;
      for (int f = 0; f < 3; f++) begin
        fr = {1'b1, b3[f], 1'b0};
        for (int i = 0; i < 20; i++) if (ser_h[s + f * 20 + i] !== fr[i / 2]) errs++;
      end
      chk("b2b_wave_errs", errs,           0);
      chk("b2b_idle_after", ser_h[s + 60], 1);
      chk("b2b_busy_drop", busy_h[s + 60], 0);
    end

    // full FIFO with continuous pushes
    clk_div = 16'd9;
    for (int k = 0; k < 6; k++) bb[k] = 8'($urandom_range(0, 255));
    mark = ser_h.size();
    n = 0;
    guard = 0;
    tx_valid = 1'b1;
    tx_data  = bb[0];
    while (n < 6 && guard < 3000) begin
      rdy = tx_ready;
      @(negedge wb_clk_i);
      guard++;
      if (rdy) begin
        n++;
        if (n == 5) chk("full_ready_low_after5", tx_ready, 0);
        if (n < 6) tx_data = bb[n];
      end
    end
    tx_valid = 1'b0;
    chk("full_all_accepted", n, 6);
    run(600);
    decode(mark, 9, 6);
    chk("full_rx_count", rx_q.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < rx_q.size()) chk("full_rx_byte", rx_q[k], bb[k]);

    // divisor change mid-frame
    clk_div = 16'd3;
    mark = ser_h.size();
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(negedge wb_clk_i);
    tx_data  = 8'h33;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
    run(8);
    clk_div = 16'd7;
    run(130);
    s = find_low(mark);
    chk("div_start_found", (s >= 0), 1);
    if (s >= 0) begin
      chk("div_f1_start_len",  low_run(s),       4);
      chk("div_f1_stop",       ser_h[s + 39],    1);
      chk("div_f2_contiguous", ser_h[s + 40],    0);
      chk("div_f2_start_len",  low_run(s + 40),  8);
      chk("div_f2_busy_last",  busy_h[s + 119],  1);
      chk("div_f2_busy_drop",  busy_h[s + 120],  0);
    end

    // reset during data bit 3
    clk_div = 16'd3;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(negedge wb_clk_i);
    tx_data  = 8'h77;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
    g = 0;
    while (ser_tx !== 1'b0 && g < 40) begin
      @(negedge wb_clk_i);
      g++;
    end
    chk("rstmid_start_seen", ser_tx, 0);
    run(17);
    chk("rstmid_bit3_low", ser_tx, 0);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    chk("rstmid_ser",   ser_tx,     1);
    chk("rstmid_level", fifo_level, 0);
    chk("rstmid_busy",  tx_busy,    0);
    chk("rstmid_ready", tx_ready,   0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1 chk("rstmid_ready_release", tx_ready, 1);
    mark = ser_h.size();
    @(negedge wb_clk_i);
    push_byte(8'h5A);
    run(60);
    decode(mark, 3, 2);
    chk("rstmid_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rstmid_rx_byte", rx_q[0], 8'h5A);

    // minimum divisor
    clk_div = 16'd0;
    mark = ser_h.size();
    push_byte(8'hFF);
    run(20);
    zeros = 0;
    for (int i = mark; i < ser_h.size(); i++) if (ser_h[i] === 1'b0) zeros++;
    chk("min_low_cycles", zeros, 1);
    s = find_low(mark);
    chk("min_start_found", (s >= 0), 1);
    if (s >= 0) begin
      chk("min_busy_last", busy_h[s + 9],  1);
      chk("min_busy_drop", busy_h[s + 10], 0);
    end

    // randomized soak against the model
    repeat (3000) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 149) == 0) clk_div = 16'($urandom_range(0, 3));
      wb_rst_i = ($urandom_range(0, 799) == 0);
      @(negedge wb_clk_i);
    end
    wb_rst_i = 1'b0;
    tx_valid = 1'b0;
    run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
